transpose_chunk_sched: RTL and testbench
========================================

Name: transpose_chunk_sched

Overview:
- Sequencer for the matrix-transpose datapath.
- Walks an ARR_SIZE x ARR_SIZE matrix chunk by chunk and presents each chunk address to address_calc.
- Pulses address_calc's ctrl and captures the returned store address.
- Moves each chunk's beats through a shared memory port using req/gnt handshakes, then signals completion.

Parameters:
- DATA_WIDTH, 32, data word width; passed through for consistency with address_calc, unused internally.
- ARR_SIZE, 8, matrix dimension in words; must be a multiple of CHUNK_SIZE.
- ADDR_WIDTH, 8, width of all address ports.
- CHUNK_SIZE, 2, chunk edge; also the number of read beats and write beats per chunk.
- Derived localparams:
  - NCHUNK = ARR_SIZE/CHUNK_SIZE
  - COL_STRIDE = ARR_SIZE
  - ROW_STRIDE = ARR_SIZE*ARR_SIZE

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transpose; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  matrix base; latched on start accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- chunk_addr  out  ADDR_WIDTH  current chunk address, registered; drives address_calc.chunk_addr.
- calc_ctrl  out  1  drives address_calc.ctrl.
- store_addr  in  ADDR_WIDTH  from address_calc.store_addr.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_gnt  in  1  read beat accepted this cycle.
- wr_req  out  1  write request.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_gnt  in  1  write beat accepted this cycle.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Counters r, c and beat clear to 0.
  - All outputs are 0, including chunk_addr, rd_addr and wr_addr.
  - The latched base and the latched store address clear to 0.
  - Reset mid-operation aborts immediately; no further req is issued and no done pulse is produced.
- Chunk address:
  - chunk_addr = base + r*ROW_STRIDE + c*COL_STRIDE, modulo 2^ADDR_WIDTH.
  - Registered, and stable for the whole chunk.
  - Chunk order: c increments first (0..NCHUNK-1), then r.
  - Defaults give 0, 8, 16, 24, 64, 72, ..., 216.
- States:
  - IDLE: when start=1, latch base, clear r, c and beat, go to RD.
  - RD: rd_req=1, rd_addr = chunk_addr + beat. On rd_gnt, beat++. If the granted beat is CHUNK_SIZE-1, clear beat and go to CALC.
  - CALC: calc_ctrl=1 for exactly one cycle, then go to WAIT.
  - WAIT: one cycle covering address_calc's registered latency. Latch store_addr at the end of this cycle, then go to WR.
  - WR: wr_req=1, wr_addr = latched store address + beat. On wr_gnt, beat++. On the last beat:
    - clear beat;
    - if r = c = NCHUNK-1, go to DONE;
    - otherwise advance c (wrapping to 0 and incrementing r), then go to RD.
  - DONE: done=1 for one cycle, then go to IDLE.
- Handshake rules:
  - req stays asserted, with a stable address, until gnt.
  - gnt while req=0 is ignored.
  - rd_req and wr_req are never high together.
- Latency: with gnt tied high, each chunk takes 2*CHUNK_SIZE+2 cycles.
- Boundaries:
  - start while busy is ignored.
  - start sampled in the DONE cycle is ignored; start is accepted again the following cycle.
  - All address sums wrap silently at ADDR_WIDTH.

Optional Feature:
- Macro: TRANSPOSE_CHUNK_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - stall_cnt increments every cycle in which (rd_req && !rd_gnt) || (wr_req && !wr_gnt).
  - It saturates at 0xFFFF, clears on rst and on start accept, and holds its value in IDLE.
- When undefined:
  - The port and the counter are absent.
  - Functional behaviour is otherwise identical.

Test Plan:
- Defaults, base=0, rd_gnt=wr_gnt=1, start pulsed at cycle 0 → chunk_addr sequence 0, 8, 16, 24, 64, 72, 80, 88, 128, ..., 216. calc_ctrl pulses 16 times, busy stays high, and done pulses at cycle 97.
- Same run, with the address_calc model returning store=chunk_addr^0x3 → the wr_addr pairs per chunk are {store, store+1}, e.g. chunk 8 gives 11, 12.
- rd_gnt held low 3 cycles on the first beat → rd_req and rd_addr=0 stay stable for 4 cycles, no beat is lost, and done arrives 3 cycles later (cycle 100). With the PERF macro, stall_cnt=3.
- base=200 → chunk_addr of chunk r=1, c=0 is (200+64) mod 256 = 8, showing wrap.
- start pulsed again at cycle 20 while busy → ignored; exactly one done is produced.
- rst asserted at cycle 30 mid-WR → next cycle busy=0 and all reqs 0. A new start after rst restarts at chunk_addr=base.

Source files
------------

// File: rtl/transpose_chunk_sched.sv
// transpose_chunk_sched: sequencer for the matrix-transpose datapath.
// Walks an ARR_SIZE x ARR_SIZE matrix chunk by chunk (column index fastest),
// hands each chunk address to address_calc, captures the returned store
// address, then moves the chunk's read and write beats over req/gnt ports.
// Optional feature: define TRANSPOSE_CHUNK_SCHED_PERF_EN to add the 16-bit
// saturating stall_cnt output counting cycles a request waits for its grant.

module transpose_chunk_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ARR_SIZE   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CHUNK_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] chunk_addr,
  output logic                  calc_ctrl,
  input  logic [ADDR_WIDTH-1:0] store_addr,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_gnt
`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int NCHUNK     = ARR_SIZE / CHUNK_SIZE;
  localparam int COL_STRIDE = ARR_SIZE;
  localparam int ROW_STRIDE = ARR_SIZE * ARR_SIZE;
  localparam int CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BEAT_W     = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;

  localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(CHUNK_SIZE - 1);

  // Reject parameter sets the sequencer cannot walk correctly.
  if ((DATA_WIDTH < 1) || (ADDR_WIDTH < 1) || (ADDR_WIDTH > 32) ||
      (CHUNK_SIZE < 1) || ((ARR_SIZE % CHUNK_SIZE) != 0)) begin : g_param_check
    $error("transpose_chunk_sched: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WAIT,
    S_WR,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        r_q, r_d;
  logic [CNT_W-1:0]        c_q, c_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   store_q, store_d;
  logic [ADDR_WIDTH-1:0]   chunk_addr_q, chunk_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    calc_ctrl_q, calc_ctrl_d;
  logic                    rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    start_accept;

  // Chunk origin for a (row, col) chunk index; the sum wraps at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] chunk_origin(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [CNT_W-1:0]      row,
    input logic [CNT_W-1:0]      col
  );
    logic [31:0] sum;
    sum = 32'(base) + (32'(row) * 32'(ROW_STRIDE)) + (32'(col) * 32'(COL_STRIDE));
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Next-state, counter and address computation; outputs are derived from the
  // next state so that every port comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    beat_d       = beat_q;
    base_d       = base_q;
    store_d      = store_q;
    chunk_addr_d = chunk_addr_q;
    start_accept = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          base_d       = base_addr;
          r_d          = '0;
          c_d          = '0;
          beat_d       = '0;
          chunk_addr_d = base_addr;
          state_d      = S_RD;
        end
      end

      S_RD: begin
        if (rd_gnt) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_CALC;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_CALC: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        store_d = store_addr;
        state_d = S_WR;
      end

      S_WR: begin
        if (wr_gnt) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if ((r_q == LAST_CHUNK) && (c_q == LAST_CHUNK)) begin
              state_d = S_DONE;
            end else begin
              if (c_q == LAST_CHUNK) begin
                c_d = '0;
                r_d = r_q + 1'b1;
              end else begin
                c_d = c_q + 1'b1;
              end
              chunk_addr_d = chunk_origin(base_q, r_d, c_d);
              state_d      = S_RD;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    calc_ctrl_d = (state_d == S_CALC);
    rd_req_d    = (state_d == S_RD);
    wr_req_d    = (state_d == S_WR);
    rd_addr_d   = rd_req_d ? (chunk_addr_d + ADDR_WIDTH'(beat_d)) : '0;
    wr_addr_d   = wr_req_d ? (store_d + ADDR_WIDTH'(beat_d)) : '0;
  end

  // Sequencer state and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      store_q      <= '0;
      chunk_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      calc_ctrl_q  <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      store_q      <= store_d;
      chunk_addr_q <= chunk_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      calc_ctrl_q  <= calc_ctrl_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign chunk_addr = chunk_addr_q;
  assign calc_ctrl  = calc_ctrl_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;

`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_now;

  // Count cycles where an outstanding request is not granted, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_now   = (rd_req_q && !rd_gnt) || (wr_req_q && !wr_gnt);
    if (start_accept) begin
      stall_cnt_d = '0;
    end else if (stall_now && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_transpose_chunk_sched.sv
// tb_transpose_chunk_sched: self-checking bench for transpose_chunk_sched.
// A behavioural model lists every chunk, read beat and write beat a full
// transpose should produce; a monitor pops that model as handshakes complete.

`timescale 1ns/1ps

module tb_transpose_chunk_sched;

  localparam int DW = 32;
  localparam int AS = 8;
  localparam int AW = 8;
  localparam int CS = 2;
  localparam int NC = AS / CS;
  localparam int CHUNK_CYCLES = 2 * CS + 2;
  localparam int DONE_CYCLE = 1 + NC * NC * CHUNK_CYCLES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] chunk_addr;
  logic          calc_ctrl;
  logic [AW-1:0] store_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt = 1'b0;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_gnt = 1'b0;
`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int numChecks = 0;
  int numFails = 0;
  int cyc = 0;
  int startCyc = 0;

  bit            initRst = 1'b1;
  bit            monEn = 1'b0;
  bit            launch = 1'b0;
  logic [AW-1:0] launchBase = '0;
  int            extraA = -1;
  int            extraB = -1;
  int            rstAt = -1;
  int            gntMode = 0;

  int doneCnt = 0;
  int doneCyc = 0;
  int calcCnt = 0;
  int busyCnt = 0;
  int stallSeen = 0;
  int rdBeats = 0;
  int wrBeats = 0;
  bit rdPend = 1'b0;
  bit wrPend = 1'b0;
  logic [AW-1:0] rdPendAddr = '0;
  logic [AW-1:0] wrPendAddr = '0;

  int expChunk[$];
  int expRd[$];
  int expWr[$];

  transpose_chunk_sched #(
    .DATA_WIDTH(DW),
    .ARR_SIZE  (AS),
    .ADDR_WIDTH(AW),
    .CHUNK_SIZE(CS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .chunk_addr(chunk_addr),
    .calc_ctrl (calc_ctrl),
    .store_addr(store_addr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_gnt    (wr_gnt)
`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp events relative to the start pulse.
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for address_calc: one registered cycle, store = chunk ^ 3.
  always @(posedge clk) begin
    if (rst) store_addr <= '0;
    else if (calc_ctrl) store_addr <= chunk_addr ^ AW'(3);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d after start)", tag, actual, expected, cyc - startCyc);
    end
  endtask

  // Reference model: every chunk origin, read beat and write beat in order.
  task automatic buildModel(input logic [AW-1:0] base);
    int ca;
    expChunk.delete();
    expRd.delete();
    expWr.delete();
    for (int r = 0; r < NC; r++) begin
      for (int c = 0; c < NC; c++) begin
        ca = (int'(base) + r * AS * AS + c * AS) % 256;
        expChunk.push_back(ca);
        for (int b = 0; b < CS; b++) begin
          expRd.push_back((ca + b) % 256);
          expWr.push_back(((ca ^ 3) + b) % 256);
        end
      end
    end
    calcCnt = 0;
    busyCnt = 0;
    stallSeen = 0;
    rdBeats = 0;
    wrBeats = 0;
  endtask

  // Input driver: owns rst, start and the grants, updated 1ns after each edge.
  initial begin : driver
    int k;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rst = initRst;
      if (launch) begin
        start = 1'b1;
        base_addr = launchBase;
        startCyc = cyc;
        launch = 1'b0;
      end
      k = cyc - startCyc;
      if (!start && (k == extraA || k == extraB)) start = 1'b1;
      if (k == rstAt) rst = 1'b1;
      case (gntMode)
        1: begin
          rd_gnt = ($urandom_range(0, 3) != 0);
          wr_gnt = ($urandom_range(0, 3) != 0);
        end
        2: begin
          rd_gnt = !(k >= 1 && k <= 3);
          wr_gnt = 1'b1;
        end
        default: begin
          rd_gnt = 1'b1;
          wr_gnt = 1'b1;
        end
      endcase
    end
  end

  // Monitor on the falling edge: scoreboard beats and chunks, check handshakes.
  always @(negedge clk) begin
    if (rst || !monEn) begin
      rdPend = 1'b0;
      wrPend = 1'b0;
    end else begin
      if (busy) busyCnt++;
      if (rd_req || wr_req) checkOutput("req_exclusive", 32'(rd_req && wr_req), 32'd0);
      if (rdPend) checkOutput("rd_hold", {rd_req, rd_addr}, {1'b1, rdPendAddr});
      if (wrPend) checkOutput("wr_hold", {wr_req, wr_addr}, {1'b1, wrPendAddr});
      if (rd_req && rd_gnt) begin
        rdBeats++;
        if (expRd.size() > 0) checkOutput("rd_addr", rd_addr, expRd.pop_front());
      end
      if (wr_req && wr_gnt) begin
        wrBeats++;
        if (expWr.size() > 0) checkOutput("wr_addr", wr_addr, expWr.pop_front());
      end
      if (calc_ctrl) begin
        calcCnt++;
        if (expChunk.size() > 0) checkOutput("chunk_addr", chunk_addr, expChunk.pop_front());
      end
      if ((rd_req && !rd_gnt) || (wr_req && !wr_gnt)) stallSeen++;
      if (done) begin
        doneCnt++;
        doneCyc = cyc - startCyc;
      end
      rdPend = rd_req && !rd_gnt;
      rdPendAddr = rd_addr;
      wrPend = wr_req && !wr_gnt;
      wrPendAddr = wr_addr;
    end
  end

  // One full transpose: mode 0 grants always, 1 random grants, 2 three-cycle
  // read stall on the first beat. Extra starts land mid-run and in DONE.
  task automatic applyStimulus(input logic [AW-1:0] base, input int mode, input bit backToBack, input bit extraStart);
    int d0;
    int expDone;
    int expStall;
    bit found;
    d0 = doneCnt;
    buildModel(base);
    gntMode = mode;
    launchBase = base;
    if (extraStart) begin
      extraA = 20;
      extraB = DONE_CYCLE;
    end
    launch = 1'b1;
    @(posedge clk);
    #2;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (doneCnt != d0) found = 1'b1;
    end
    checkOutput("done_seen", 32'(found), 32'd1);
    if (found) begin
      expStall = (mode == 2) ? 3 : ((mode == 1) ? stallSeen : 0);
      expDone = DONE_CYCLE + expStall;
      checkOutput("done_cycle", doneCyc, expDone);
      checkOutput("busy_cycles", busyCnt, expDone);
      checkOutput("calc_pulses", calcCnt, NC * NC);
      checkOutput("rd_beats", rdBeats, NC * NC * CS);
      checkOutput("wr_beats", wrBeats, NC * NC * CS);
`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
      checkOutput("stall_cnt", 32'(stall_cnt), expStall);
`endif
    end
    if (!backToBack) begin
      repeat (6) @(negedge clk);
      #1;
      checkOutput("single_done", doneCnt - d0, 1);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end
    extraA = -1;
    extraB = -1;
  endtask

  // Reset asserted during cycle 30 (mid-WR) must abort without a done pulse.
  task automatic runResetAbort(input logic [AW-1:0] base);
    int d0;
    int activity;
    buildModel(base);
    gntMode = 0;
    launchBase = base;
    rstAt = 30;
    launch = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 200 && (cyc - startCyc) != 31; i++) @(negedge clk);
    #1;
    checkOutput("rst_reached", cyc - startCyc, 31);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
    checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_calc", 32'(calc_ctrl), 32'd0);
    checkOutput("rst_chunk_addr", chunk_addr, 32'd0);
    checkOutput("rst_rd_addr", rd_addr, 32'd0);
    checkOutput("rst_wr_addr", wr_addr, 32'd0);
`ifdef TRANSPOSE_CHUNK_SCHED_PERF_EN
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    d0 = doneCnt;
    activity = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (rd_req || wr_req || busy) activity++;
    end
    checkOutput("post_rst_quiet", activity, 0);
    checkOutput("post_rst_no_done", doneCnt - d0, 0);
    rstAt = -1;
    expChunk.delete();
    expRd.delete();
    expWr.delete();
  endtask

  // Test sequence: reset values, directed scenarios, then randomized runs.
  initial begin
    repeat (4) @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_calc", 32'(calc_ctrl), 32'd0);
    checkOutput("reset_reqs", {rd_req, wr_req}, 32'd0);
    checkOutput("reset_chunk_addr", chunk_addr, 32'd0);
    checkOutput("reset_rd_addr", rd_addr, 32'd0);
    checkOutput("reset_wr_addr", wr_addr, 32'd0);
    initRst = 1'b0;
    @(negedge clk);
    monEn = 1'b1;

    $display("[TB] base 0, grants tied high");
    applyStimulus(8'd0, 0, 1'b0, 1'b0);
    $display("[TB] first read beat stalled three cycles");
    applyStimulus(8'd0, 2, 1'b0, 1'b0);
    $display("[TB] base 200, address wrap");
    applyStimulus(8'd200, 0, 1'b0, 1'b0);
    $display("[TB] start while busy and in DONE");
    applyStimulus(8'd5, 0, 1'b0, 1'b1);
    $display("[TB] back-to-back start right after DONE");
    applyStimulus(8'd17, 0, 1'b1, 1'b0);
    applyStimulus(8'd33, 0, 1'b0, 1'b0);
    $display("[TB] reset mid-operation, then restart");
    runResetAbort(8'd40);
    applyStimulus(8'd40, 0, 1'b0, 1'b0);
    $display("[TB] randomized grants and bases");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(AW'($urandom_range(0, 255)), 1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
